// File: rtl/div_remainder_unit.sv
// Iterative signed restoring divider for the multdiv path.
// Optional macro DIV_EARLY_OUT_EN: skip iterations when |A| < |B|.
module div_remainder_unit #(
  parameter int WIDTH    = 32,
  parameter int CNT_BITS = 6
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};
  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(WIDTH-1);

  logic [1:0]           state;
  logic                 sign_a;
  logic                 sign_b;
  logic                 div_zero;
  logic                 ovf;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [2*WIDTH-1:0]   rq;
  logic [CNT_BITS-1:0]  cnt;

  logic [WIDTH:0]       top;
  logic [WIDTH:0]       trial;
  logic [2*WIDTH-1:0]   rq_step;
  logic [WIDTH-1:0]     q_lo;
  logic [WIDTH-1:0]     r_hi;

  // One restoring step: shift left, trial-subtract, keep or restore.
  // The bit shifted out of the upper half is kept so large divisors work.
  always_comb begin
    top   = rq[2*WIDTH-1:WIDTH-1];
    trial = top - {1'b0, mag_b};
    q_lo  = rq[WIDTH-1:0];
    r_hi  = rq[2*WIDTH-1:WIDTH];
    if (!trial[WIDTH]) begin
      rq_step = {trial[WIDTH-1:0], rq[WIDTH-2:0], 1'b1};
    end else begin
      rq_step = {top[WIDTH-1:0], rq[WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM, operand capture, iteration and result registers.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state          <= S_IDLE;
      sign_a         <= 1'b0;
      sign_b         <= 1'b0;
      div_zero       <= 1'b0;
      ovf            <= 1'b0;
      mag_a          <= '0;
      mag_b          <= '0;
      rq             <= '0;
      cnt            <= '0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          data_resultRDY <= 1'b0;
          if (ctrl_DIV) begin
            sign_a         <= data_operandA[WIDTH-1];
            sign_b         <= data_operandB[WIDTH-1];
            mag_a          <= data_operandA[WIDTH-1] ?
                              -data_operandA : data_operandA;
            mag_b          <= data_operandB[WIDTH-1] ?
                              -data_operandB : data_operandB;
            div_zero       <= (data_operandB == '0);
            ovf            <= (data_operandA == MIN_NEG) &&
                              (data_operandB == ALL_ONE);
            data_exception <= 1'b0;
            busy           <= 1'b1;
            state          <= S_LOAD;
          end
        end
        S_LOAD: begin
          cnt <= '0;
          if (div_zero || ovf) begin
            state <= S_DONE;
`ifdef DIV_EARLY_OUT_EN
          end else if (mag_a < mag_b) begin
            // Quotient is zero; the whole dividend is the remainder.
            rq    <= {mag_a, {WIDTH{1'b0}}};
            state <= S_DONE;
`endif
          end else begin
            rq    <= {{WIDTH{1'b0}}, mag_a};
            state <= S_ITER;
          end
        end
        S_ITER: begin
          rq  <= rq_step;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // First DONE cycle publishes; second drops the pulse.
          if (!data_resultRDY) begin
            data_resultRDY <= 1'b1;
            if (div_zero || ovf) begin
              data_result    <= '0;
              data_remainder <= '0;
              data_exception <= 1'b1;
            end else begin
              data_result    <= (sign_a ^ sign_b) ? -q_lo : q_lo;
              data_remainder <= sign_a ? -r_hi : r_hi;
              data_exception <= 1'b0;
            end
          end else begin
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
            state          <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
